// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the PC generator / instruction fetch unit.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK  = 32'(INSTR_BYTES - 1);

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection (sequential or JALR) with alignment check.
module pc_next_calc
    import pc_gen_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] offset_in,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);

    always_comb begin
        next_pc  = '0;
        misalign = 1'b0;
        // Bit 0 of a JALR target is always cleared; bit 1 can still trip the misalign flag.
        if (jalr_en) begin
            next_pc = jalr_target & ~32'h1;
        end else begin
            next_pc = pc + offset_in;
        end
        misalign = (next_pc & ALIGN_MASK) != '0;
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter and single-outstanding instruction fetch FSM with a one-entry hold buffer.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] offset_in,
    input  logic        offset_valid,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign_err
);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        misalign;
    logic        advance;
    logic        capture;

    pc_next_calc u_pc_next_calc (
        .pc          (pc),
        .offset_in   (offset_in),
        .jalr_en     (jalr_en),
        .jalr_target (jalr_target),
        .next_pc     (next_pc),
        .misalign    (misalign)
    );

    assign advance   = (state == S_HOLD) && instr_ready && offset_valid;
    assign capture   = (state == S_WAIT) && imem_rvalid;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) state_next = S_WAIT;
            end
            S_WAIT: if (imem_rvalid) state_next = S_HOLD;
            S_HOLD: if (advance) state_next = misalign ? S_ERR : S_REQ;
            S_ERR:  state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    // rvalid outside WAIT (including stale responses after reset) never reaches the hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            instr_out    <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (capture) begin
                instr_out   <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end
            if (advance) begin
                instr_valid <= 1'b0;
                if (misalign) begin
                    misalign_err <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 offset_in  input  32  PC offset from the branch unit (32'h4 or the branch immediate).
REQ-005 offset_valid  input  1  offset_in is valid for the instruction currently held.
REQ-006 jalr_en  input  1  use jalr_target instead of pc+offset_in.
REQ-007 jalr_target  input  32  absolute JALR target.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address; always equals the PC register.
REQ-010 imem_gnt  input  1  memory accepted the request.
REQ-011 imem_rvalid  input  1  imem_rdata valid.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 instr_out  output  32  held instruction.
REQ-014 instr_pc  output  32  PC of instr_out.
REQ-015 instr_valid  output  1  instr_out/instr_pc are valid.
REQ-016 instr_ready  input  1  downstream consumes the held instruction.
REQ-017 misalign_err  output  1  sticky; next PC was not 4-byte aligned.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD, ERR.
REQ-019 IDLE: imem_req=0; transition to REQ unconditionally on the next cycle.
REQ-020 REQ: imem_req=1 with imem_addr=pc; on imem_gnt=1 go to WAIT; otherwise remain in REQ with the address stable.
REQ-021 WAIT: imem_req=0; on imem_rvalid=1 register instr_out<=imem_rdata, instr_pc<=pc, go to HOLD.
REQ-022 imem_rvalid is ignored in every state except WAIT; one fetch is outstanding at most.
REQ-023 HOLD: instr_valid=1; instr_out/instr_pc stay stable until advance.
REQ-024 Advance = HOLD & instr_ready & offset_valid; without all three, remain in HOLD.
REQ-025 next_pc = jalr_en ? {jalr_target[31:1],1'b0} : pc + offset_in, modulo 2^32 (wrap, no carry out).
REQ-026 On advance with next_pc[1:0]==2'b00: pc<=next_pc, instr_valid<=0, go to REQ; the next imem_req is asserted in the following cycle.
REQ-027 On advance with next_pc[1:0]!=2'b00: pc unchanged, misalign_err<=1, instr_valid<=0, go to ERR.
REQ-028 ERR: imem_req=0, instr_valid=0, misalign_err=1; exit only by reset.
REQ-029 Fetch latency: instr_valid rises 1 cycle after the imem_rvalid edge; minimum fetch loop is 3 cycles (REQ->WAIT->HOLD) from advance to instr_valid.
REQ-030 The offset is signed only through 32-bit wrap; pc+32'hFFFF_FFFC yields pc-4.

Reset
REQ-031 While rst=1: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, misalign_err=0.
REQ-032 Reset mid-fetch abandons the outstanding request; a stale imem_rvalid arriving after reset release, before WAIT is entered, is dropped.

Structure
REQ-033 A shared package pc_gen_pkg shall hold the state enum type and the constant INSTR_BYTES=4.
REQ-034 One combinational sub-module, pc_next_calc, shall compute next_pc and the misalign flag; the FSM and registers stay in pc_gen.

Verification
REQ-035 Reset release, gnt on first REQ cycle, rvalid 1 cycle later with 32'h0000_0013 -> imem_addr=0, instr_out=32'h13, instr_pc=0, instr_valid high.
REQ-036 HOLD at pc=0x100, offset_in=4, ready+valid -> next imem_addr=0x104; then offset_in=32'hFFFF_FFF0 -> imem_addr=0xF4.
REQ-037 jalr_en=1, jalr_target=0x0000_2001 -> imem_addr=0x2000, no error.
REQ-038 offset_in=32'h2 at advance -> misalign_err=1, instr_valid=0, imem_req stays 0 for 10 cycles; pc unchanged.
REQ-039 imem_gnt held low 5 cycles -> imem_req and imem_addr stable throughout; spurious imem_rvalid in REQ ignored.
REQ-040 rst asserted in WAIT, rvalid pulses 1 cycle after release -> instr_valid remains 0, fetch restarts at RESET_PC.
